// File: rtl/asip_isa_pkg.sv
// rtl/asip_isa_pkg.sv - ASIP instruction field layout, opcodes and encoder FSM state
package asip_isa_pkg;

  localparam logic [1:0] OP_DP     = 2'b00;
  localparam logic [1:0] OP_MEM    = 2'b01;
  localparam logic [1:0] OP_BR     = 2'b10;
  localparam logic [1:0] OP_UNIMPL = 2'b11;

  localparam int COND_W  = 4;
  localparam int OP_W    = 2;
  localparam int FUNCT_W = 7;
  localparam int REG_W   = 4;
  localparam int SRC2_W  = 11;
  localparam int INSTR_W = COND_W + OP_W + FUNCT_W + 2 * REG_W + SRC2_W;

  // Member order is the bit order of the word, MSB first.
  typedef struct packed {
    logic [COND_W-1:0]  cond;
    logic [OP_W-1:0]    op;
    logic [FUNCT_W-1:0] funct;
    logic [REG_W-1:0]   rn;
    logic [REG_W-1:0]   rd;
    logic [SRC2_W-1:0]  src2;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } enc_state_e;

  function automatic logic is_illegal(input logic [OP_W-1:0] op, input logic [FUNCT_W-1:0] funct);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_DP:     bad = (funct[2:0] == 3'b110) || (funct[2:0] == 3'b111);
      OP_MEM:    bad = (funct[6:5] == 2'b01) || (funct[6:5] == 2'b10);
      OP_BR:     bad = 1'b0;
      OP_UNIMPL: bad = 1'b1;
      default:   bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - synchronous FIFO holding encoded words awaiting a memory write
module instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit tells a full buffer from an empty one.
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[PW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs decoded fields into instruction words and loads them into memory
// Optional legality screening and sticky err flag when ENCODER_LEGAL_CHECK_EN is defined.
module instr_encoder_loader
  import asip_isa_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [6:0]        in_funct,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [10:0]       in_src2,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_cnt,
  output logic              err
);

  enc_state_e           state;
  enc_state_e           state_nxt;
  logic [ADDR_W-1:0]    addr;
  instr_t               enc_word;
  logic [INSTR_W-1:0]   fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 accept;
  logic                 wr_fire;
  logic                 illegal;
  logic                 session_start;

  assign enc_word      = '{cond: in_cond, op: in_op, funct: in_funct, rn: in_rn, rd: in_rd, src2: in_src2};
  assign accept        = in_valid && in_ready;
  assign wr_fire       = mem_we && mem_ready;
  assign fifo_push     = accept && !illegal;
  assign session_start = (state == ST_IDLE) && start;

`ifdef ENCODER_LEGAL_CHECK_EN
  logic err_q;

  assign illegal = is_illegal(in_op, in_funct);
  assign err     = err_q;

  // Illegal bundles complete the handshake but are dropped; the flag survives until the next session.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (session_start) begin
      err_q <= 1'b0;
    end else if (accept && illegal) begin
      err_q <= 1'b1;
    end
  end
`else
  assign illegal = 1'b0;
  assign err     = 1'b0;
`endif

  instr_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (enc_word),
    .pop       (wr_fire),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (accept && in_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_RUN: begin
        busy     = 1'b1;
        in_ready = !fifo_full;
        mem_we   = !fifo_empty;
      end
      ST_DRAIN: begin
        busy   = 1'b1;
        mem_we = !fifo_empty;
      end
      ST_FIN: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Address wraps naturally; the word count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      word_cnt <= '0;
    end else if (session_start) begin
      addr     <= base_addr;
      word_cnt <= '0;
    end else if (wr_fire) begin
      addr <= addr + 1'b1;
      if (word_cnt != '1) begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  assign mem_addr  = addr;
  assign mem_wdata = fifo_head;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed self-checking bench for instr_encoder_loader
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = '0;
  logic [6:0]  in_funct = '0;
  logic [3:0]  in_cond = '0;
  logic [3:0]  in_rn = '0;
  logic [3:0]  in_rd = '0;
  logic [10:0] in_src2 = '0;
  logic        in_last = 1'b0;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b1;
  logic        busy;
  logic        done;
  logic [10:0] word_cnt;
  logic        err;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  instr_encoder_loader #(.ADDR_W(10), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_funct(in_funct),
    .in_cond(in_cond), .in_rn(in_rn), .in_rd(in_rd), .in_src2(in_src2), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .word_cnt(word_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Writes and done pulses are observed mid-cycle, before the completing edge.
  always @(negedge clk) begin
    if (mem_we && mem_ready) begin
      log_addr.push_back(32'(mem_addr));
      log_data.push_back(mem_wdata);
    end
    if (done) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic do_start(input logic [9:0] base);
    start = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [6:0] fn, input logic [3:0] cd,
                      input logic [3:0] rn, input logic [3:0] rd, input logic [10:0] s2,
                      input logic last);
    int t;
    bit ok;
    t = 0;
    ok = 1'b0;
    in_op = op; in_funct = fn; in_cond = cd; in_rn = rn; in_rd = rd; in_src2 = s2;
    in_last = last;
    in_valid = 1'b1;
    while (!ok && t < 100) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      t++;
    end
    if (!ok) check_eq("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    acc_cnt++;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic check_log(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < log_addr.size()) begin
      check_eq({tag, "_addr"}, log_addr[idx], a);
      check_eq({tag, "_data"}, log_data[idx], d);
    end else begin
      check_eq({tag, "_missing"}, 32'(log_addr.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    int lb;
    int d0;
    int exp_n;
    logic exp_err;

    // Reset state
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Three-instruction program at 0x010
    lb = log_addr.size(); d0 = done_cnt;
    do_start(10'h010);
    check_eq("t1_busy", 32'(busy), 32'd1);
    send(2'b00, 7'h10, 4'hE, 4'd2, 4'd1, 11'd5, 1'b0);
    check_eq("t1_latency_we", 32'(mem_we), 32'd1);
    check_eq("t1_latency_wdata", mem_wdata, 32'hE081_0805);
    send(2'b01, 7'h19, 4'hE, 4'd3, 4'd4, 11'h008, 1'b0);
    send(2'b10, 7'h00, 4'hE, 4'd0, 4'd0, 11'h7FF, 1'b1);
    wait_done("t1", d0);
    check_eq("t1_nwrites", 32'(log_addr.size() - lb), 32'd3);
    check_log("t1_w0", lb + 0, 32'h010, 32'hE081_0805);
    check_log("t1_w1", lb + 1, 32'h011, 32'hE4C9_A008);
    check_log("t1_w2", lb + 2, 32'h012, 32'hE800_07FF);
    check_eq("t1_word_cnt", 32'(word_cnt), 32'd3);

    // Field placement vector
    lb = log_addr.size(); d0 = done_cnt;
    do_start(10'h100);
    send(2'b00, 7'h60, 4'h0, 4'd3, 4'd4, 11'd5, 1'b1);
    wait_done("t2", d0);
    check_log("t2_w0", lb, 32'h100, 32'h0301_A005);
    check_eq("t2_word_cnt", 32'(word_cnt), 32'd1);

    // Back-pressure: memory stalled while 6 bundles are offered
    lb = log_addr.size(); d0 = done_cnt;
    mem_ready = 1'b0;
    acc_cnt = 0;
    do_start(10'h200);
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(2'b00, 7'h00, 4'h0, 4'd0, 4'd0, 11'(11'h100 + i), (i == 5));
        end
      end
      begin
        repeat (10) @(negedge clk);
        check_eq("t3_accepted_stalled", 32'(acc_cnt), 32'd4);
        check_eq("t3_in_ready_full", 32'(in_ready), 32'd0);
        check_eq("t3_we_held", 32'(mem_we), 32'd1);
        check_eq("t3_addr_held", 32'(mem_addr), 32'h200);
        check_eq("t3_wdata_held", mem_wdata, 32'h100);
        @(posedge clk); #1;
        mem_ready = 1'b1;
      end
    join
    wait_done("t3", d0);
    check_eq("t3_nwrites", 32'(log_addr.size() - lb), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check_log("t3_w", lb + i, 32'h200 + 32'(i), 32'h100 + 32'(i));
    end
    check_eq("t3_word_cnt", 32'(word_cnt), 32'd6);

    // Address wrap at the top of memory
    lb = log_addr.size(); d0 = done_cnt;
    do_start(10'h3FE);
    for (int i = 0; i < 4; i++) begin
      send(2'b00, 7'h00, 4'h0, 4'd0, 4'd0, 11'(11'h010 + i), (i == 3));
    end
    wait_done("t4", d0);
    check_log("t4_w0", lb + 0, 32'h3FE, 32'h010);
    check_log("t4_w1", lb + 1, 32'h3FF, 32'h011);
    check_log("t4_w2", lb + 2, 32'h000, 32'h012);
    check_log("t4_w3", lb + 3, 32'h001, 32'h013);
    check_eq("t4_word_cnt", 32'(word_cnt), 32'd4);

    // Asynchronous reset in the middle of a session
    lb = log_addr.size();
    do_start(10'h050);
    send(2'b00, 7'h00, 4'h0, 4'd0, 4'd0, 11'h021, 1'b0);
    send(2'b00, 7'h00, 4'h0, 4'd0, 4'd0, 11'h022, 1'b0);
    send(2'b00, 7'h00, 4'h0, 4'd0, 4'd0, 11'h023, 1'b0);
    check_eq("t5_writes_before_rst", 32'(log_addr.size() - lb), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    lb = log_addr.size(); d0 = done_cnt;
    do_start(10'h060);
    send(2'b00, 7'h00, 4'h0, 4'd0, 4'd0, 11'h024, 1'b1);
    wait_done("t5", d0);
    check_eq("t5_nwrites", 32'(log_addr.size() - lb), 32'd1);
    check_log("t5_w0", lb, 32'h060, 32'h024);
    check_eq("t5_word_cnt", 32'(word_cnt), 32'd1);

    // Unimplemented opcode between two legal bundles
`ifdef ENCODER_LEGAL_CHECK_EN
    exp_n = 2;
    exp_err = 1'b1;
`else
    exp_n = 3;
    exp_err = 1'b0;
`endif
    lb = log_addr.size(); d0 = done_cnt;
    do_start(10'h300);
    send(2'b00, 7'h00, 4'h0, 4'd0, 4'd0, 11'h001, 1'b0);
    send(2'b11, 7'h00, 4'h0, 4'd0, 4'd0, 11'h002, 1'b0);
    send(2'b00, 7'h00, 4'h0, 4'd0, 4'd0, 11'h003, 1'b1);
    wait_done("t6", d0);
    check_eq("t6_nwrites", 32'(log_addr.size() - lb), 32'(exp_n));
    check_eq("t6_err", 32'(err), 32'(exp_err));
    check_log("t6_first", lb, 32'h300, 32'h001);
    check_log("t6_last", lb + exp_n - 1, 32'h300 + 32'(exp_n - 1), 32'h003);
    d0 = done_cnt;
    do_start(10'h310);
    check_eq("t6_err_cleared", 32'(err), 32'd0);
    send(2'b00, 7'h00, 4'h0, 4'd0, 4'd0, 11'h004, 1'b1);
    wait_done("t6b", d0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
